// File: rtl/sad_col_if.sv
// Column handshake bundle between candidate fetch and the SAD scheduler.
// col_valid/col_data come from the producer; col_ready is returned by the consumer.
interface sad_col_if;
  logic        col_valid;
  logic        col_ready;
  logic [99:0] col_data;

  modport master (
    output col_valid,
    output col_data,
    input  col_ready
  );

  modport slave (
    input  col_valid,
    input  col_data,
    output col_ready
  );
endinterface

// File: rtl/sad_column_scheduler.sv
// Column-SAD scheduler: popcounts 100-bit XOR'd columns, sums NCOL per
// candidate and tracks min SAD/index over NCAND candidates.
// Ports: clk, rst (async high), start, col (slave handshake: valid/ready/data),
// busy, cand_valid/cand_sad (per candidate), done/best_sad/best_idx (per search).

module treeadder (
  input  logic [99:0] din,
  output logic [7:0]  cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 100; i++)
      cnt = cnt + 8'(din[i]);
  end
endmodule

module sad_column_scheduler #(
  parameter int NCOL  = 16,
  parameter int NCAND = 8,
  localparam int SAD_W = $clog2(NCOL*100+1),
  localparam int IDX_W = $clog2(NCAND),
  localparam int COL_W = $clog2(NCOL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  sad_col_if.slave         col,
  output logic             busy,
  output logic             cand_valid,
  output logic [SAD_W-1:0] cand_sad,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [COL_W-1:0] col_cnt;
  logic [IDX_W-1:0] cand_cnt;
  logic [99:0]      din_q;
  logic             p_v;
  logic             p_last;
  logic [IDX_W-1:0] p_idx;
  logic [SAD_W-1:0] acc;
  logic [7:0]       pop;
  logic [SAD_W-1:0] sum;
  logic             accept;
  logic             last_col;
  logic             last_cand;

  treeadder u_tree (
    .din (din_q),
    .cnt (pop)
  );

  assign col.col_ready = (state == RUN);
  assign busy          = (state != IDLE);
  assign accept        = col.col_valid & col.col_ready;
  assign last_col      = (col_cnt == COL_W'(NCOL-1));
  assign last_cand     = (cand_cnt == IDX_W'(NCAND-1));
  assign sum           = acc + SAD_W'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col_cnt    <= '0;
      cand_cnt   <= '0;
      din_q      <= '0;
      p_v        <= 1'b0;
      p_last     <= 1'b0;
      p_idx      <= '0;
      acc        <= '0;
      cand_valid <= 1'b0;
      cand_sad   <= '0;
      done       <= 1'b0;
      best_sad   <= '1;
      best_idx   <= '0;
    end else begin
      cand_valid <= 1'b0;
      done       <= (state == DRAIN);
      p_v        <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            col_cnt  <= '0;
            cand_cnt <= '0;
            acc      <= '0;
            best_sad <= '1;
            best_idx <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            din_q  <= col.col_data;
            p_v    <= 1'b1;
            p_last <= last_col;
            p_idx  <= cand_cnt;
            if (last_col) begin
              col_cnt <= '0;
              if (last_cand) begin
                cand_cnt <= '0;
                state    <= DRAIN;
              end else begin
                cand_cnt <= cand_cnt + 1'b1;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        DRAIN: state <= DONE;
        DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase

      // Stage 2 only ever holds a column in RUN/DRAIN, so it never
      // collides with the start-time clears above.
      if (p_v) begin
        if (p_last) begin
          cand_sad   <= sum;
          cand_valid <= 1'b1;
          acc        <= '0;
          // Strict compare: ties keep the earlier candidate.
          if (sum < best_sad) begin
            best_sad <= sum;
            best_idx <= p_idx;
          end
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_sad_column_scheduler.sv
// Scoreboard bench for sad_column_scheduler.
// Directed searches; a negedge monitor pops expected candidate/best values.
module tb_sad_column_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        cand_valid;
  logic [10:0] cand_sad;
  logic        done;
  logic [10:0] best_sad;
  logic [2:0]  best_idx;

  sad_col_if cif ();

  always #5 clk = ~clk;

  sad_column_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .col        (cif),
    .busy       (busy),
    .cand_valid (cand_valid),
    .cand_sad   (cand_sad),
    .done       (done),
    .best_sad   (best_sad),
    .best_idx   (best_idx)
  );

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int done_seen = 0;
  int ready_drop = 0;

  logic [10:0] exp_sad_q[$];
  logic [13:0] exp_best_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [99:0] col_word(input int k, input int rot);
    logic [99:0] w;
    w = '0;
    for (int b = 0; b < k; b++)
      w[(b + rot) % 100] = 1'b1;
    return w;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && cif.col_valid && cif.col_ready)
      accepts++;
    if (cand_valid) begin
      if (exp_sad_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cand_valid: unexpected pulse, cand_sad=%0d", cand_sad);
      end else begin
        chk("cand_sad", int'(cand_sad), int'(exp_sad_q.pop_front()));
      end
    end
    if (done) begin
      done_seen++;
      if (exp_best_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done: unexpected pulse, best_sad=%0d", best_sad);
      end else begin
        logic [13:0] e;
        e = exp_best_q.pop_front();
        chk("best_sad", int'(best_sad), int'(e[13:3]));
        chk("best_idx", int'(best_idx), int'(e[2:0]));
      end
    end
  end

  task automatic send_col(input logic [99:0] d, input int gap);
    cif.col_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      if (!cif.col_ready) ready_drop++;
      @(posedge clk);
      #1;
    end
    cif.col_valid = 1'b1;
    cif.col_data  = d;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (cif.col_ready) break;
      if (n > 40) begin
        checks++;
        errors++;
        $display("FAIL col_ready_timeout: got 0 expected 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    cif.col_valid = 1'b0;
  endtask

  // kind: 0 all-zero, 1 decreasing ones, 2 all-ones
  task automatic run_search(input int kind, input bit gaps, input bit start_mid,
                            input bit hold, input int ncols,
                            input int bsad, input int bidx);
    int d0;
    int ones;
    d0 = done_seen;
    accepts = 0;
    ready_drop = 0;
    if (ncols == 128)
      exp_best_q.push_back({11'(bsad), 3'(bidx)});
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int j = 0; j < 16; j++) begin
        if (c * 16 + j >= ncols) return;
        ones = (kind == 0) ? 0 : (kind == 1) ? 100 - 10 * c : 100;
        if (j == 15) exp_sad_q.push_back(11'(16 * ones));
        if (start_mid && c == 4 && j == 0) start = 1'b1;
        send_col(col_word(ones, j * 7 + c), gaps ? int'($urandom_range(0, 2)) : 0);
        start = 1'b0;
      end
    end
    if (hold) begin
      cif.col_valid = 1'b1;
      cif.col_data  = '1;
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done_seen > d0) break;
    end
    chk("done_count", done_seen - d0, 1);
    repeat (4) @(posedge clk);
    #1 cif.col_valid = 1'b0;
    @(negedge clk);
    chk("accepts", accepts, 128);
    chk("ready_drop", ready_drop, 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    cif.col_valid = 1'b0;
    cif.col_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_best_sad", int'(best_sad), 2047);
    chk("rst_best_idx", int'(best_idx), 0);
    chk("rst_cand_sad", int'(cand_sad), 0);
    chk("rst_cand_valid", int'(cand_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_col_ready", int'(cif.col_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // T1 zeros, T2 decreasing, T3 all-ones tie
    run_search(0, 1'b0, 1'b0, 1'b0, 128, 0, 0);
    run_search(1, 1'b0, 1'b0, 1'b0, 128, 480, 7);
    run_search(2, 1'b0, 1'b0, 1'b0, 128, 1600, 0);
    // T4 gaps
    run_search(1, 1'b1, 1'b0, 1'b0, 128, 480, 7);
    // T5 start during RUN, valid held through DONE/IDLE
    run_search(1, 1'b0, 1'b1, 1'b1, 128, 480, 7);
    chk("idle_best_hold", int'(best_sad), 480);

    // T6 reset mid-candidate 3
    run_search(1, 1'b0, 1'b0, 1'b0, 53, 0, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_busy", int'(busy), 0);
    chk("t6_best_sad", int'(best_sad), 2047);
    chk("t6_best_idx", int'(best_idx), 0);
    chk("t6_col_ready", int'(cif.col_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_search(1, 1'b0, 1'b0, 1'b0, 128, 480, 7);

    repeat (3) @(negedge clk);
    chk("sad_q_empty", exp_sad_q.size(), 0);
    chk("best_q_empty", exp_best_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
